// File: rtl/conv_writeback.sv
// Write-back stage of the 2-D convolution engine: rescales each result to an
// unsigned pixel, queues it in a small FIFO and writes it out over a ready/valid port.
module conv_writeback #(
  parameter int AddressBitWidth = 17,
  parameter int DataBitWidth    = 12,
  parameter int OutBitWidth     = 8,
  parameter int Shift           = 2,
  parameter int FifoDepthLog2   = 2,
  parameter int TotalPixels     = 2500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       wr_en_in,
  input  logic [AddressBitWidth-1:0] wr_addr_in,
  input  logic [DataBitWidth-1:0]    d_in,
  output logic                       mem_we,
  output logic [AddressBitWidth-1:0] mem_addr,
  output logic [OutBitWidth-1:0]     mem_data,
  input  logic                       mem_ready,
  output logic                       done,
  output logic                       overflow,
  output logic                       busy
);

  localparam int FifoDepth     = 1 << FifoDepthLog2;
  localparam int CountBitWidth = $clog2(TotalPixels + 1);
  localparam logic [CountBitWidth-1:0]   LastCount = CountBitWidth'(TotalPixels - 1);
  localparam logic [FifoDepthLog2:0]     FullLevel = (FifoDepthLog2 + 1)'(FifoDepth);
  localparam logic [OutBitWidth-1:0]     MaxOut    = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic signed [DataBitWidth-1:0] shifted;
  logic [OutBitWidth-1:0]         conv_value;

  logic                       stage_valid_reg;
  logic [AddressBitWidth-1:0] stage_addr_reg;
  logic [OutBitWidth-1:0]     stage_data_reg;

  logic [AddressBitWidth-1:0] fifo_addr_mem [FifoDepth];
  logic [OutBitWidth-1:0]     fifo_data_mem [FifoDepth];
  logic [FifoDepthLog2-1:0]   wr_ptr_reg;
  logic [FifoDepthLog2-1:0]   rd_ptr_reg;
  logic [FifoDepthLog2:0]     fill_reg;

  logic [CountBitWidth-1:0]   pixel_count_reg;
  logic                       overflow_reg;

  logic accept_in;
  logic fifo_full;
  logic pop;
  logic push_ok;
  logic drop;
  logic frame_last;
  logic flush;

  // Rescale: arithmetic shift, clamp negatives, saturate the top. Requires
  // DataBitWidth > OutBitWidth + 1 so the saturation slice is non-empty.
  always_comb begin
    shifted    = $signed(d_in) >>> Shift;
    conv_value = shifted[OutBitWidth-1:0];
    if (shifted[DataBitWidth-1]) begin
      conv_value = '0;
    end else if (|shifted[DataBitWidth-2:OutBitWidth]) begin
      conv_value = MaxOut;
    end
  end

  assign mem_we     = (fill_reg != '0);
  assign fifo_full  = (fill_reg == FullLevel);
  assign pop        = mem_we && mem_ready;
  assign push_ok    = stage_valid_reg && (!fifo_full || pop);
  assign drop       = stage_valid_reg && !push_ok;
  assign accept_in  = (state_reg == ACTIVE) && wr_en_in && !start;
  assign frame_last = (state_reg == ACTIVE) && pop && (pixel_count_reg == LastCount);
  // Ending the frame also empties the pipeline so DONE never holds stray entries.
  assign flush      = start || frame_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (start) begin
          state_next = ACTIVE;
        end else if (frame_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) state_next = ACTIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid_reg <= 1'b0;
      stage_addr_reg  <= '0;
      stage_data_reg  <= '0;
    end else begin
      stage_valid_reg <= accept_in && !flush;
      if (accept_in) begin
        stage_addr_reg <= wr_addr_in;
        stage_data_reg <= conv_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + FifoDepthLog2'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + FifoDepthLog2'(1);
      case ({push_ok, pop})
        2'b10:   fill_reg <= fill_reg + (FifoDepthLog2 + 1)'(1);
        2'b01:   fill_reg <= fill_reg - (FifoDepthLog2 + 1)'(1);
        default: fill_reg <= fill_reg;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while the fill level covers them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr_mem[wr_ptr_reg] <= stage_addr_reg;
      fifo_data_mem[wr_ptr_reg] <= stage_data_reg;
    end
  end

  assign mem_addr = mem_we ? fifo_addr_mem[rd_ptr_reg] : '0;
  assign mem_data = mem_we ? fifo_data_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pixel_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else if (start) begin
      pixel_count_reg <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      if (pop && (state_reg == ACTIVE)) begin
        pixel_count_reg <= pixel_count_reg + CountBitWidth'(1);
      end
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign overflow = overflow_reg;
  assign done     = (state_reg == DONE);
  assign busy     = (state_reg == ACTIVE);

endmodule

// File: tb/tb_conv_writeback.sv
// Scoreboard bench for conv_writeback: expected writes are queued as results are
// driven and compared against every memory transfer.
module tb_conv_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wr_en_in;
  logic [16:0] wr_addr_in;
  logic [11:0] d_in;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        done;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int wcount   = 0;
  logic [24:0] sb[$];

  always #5 clk = ~clk;

  conv_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_en_in   (wr_en_in),
    .wr_addr_in (wr_addr_in),
    .d_in       (d_in),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .done       (done),
    .overflow   (overflow),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_conv(input logic [11:0] d);
    int s;
    s = int'($signed(d)) >>> 2;
    if (s < 0) return 8'h00;
    if (s > 255) return 8'hFF;
    return 8'(s);
  endfunction

  // Monitor: every transfer pops the scoreboard; a stalled write must hold.
  logic        hold_prev = 1'b0;
  logic        start_at_edge = 1'b0;
  logic [16:0] prev_addr;
  logic [7:0]  prev_data;
  logic [24:0] exp_entry;

  always @(posedge clk) start_at_edge = start;

  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !start_at_edge) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, prev_addr);
        check("hold_data", mem_data, prev_data);
      end
      if (mem_we && mem_ready) begin
        wcount++;
        check("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_entry = sb.pop_front();
          check("wr_addr", mem_addr, exp_entry[24:8]);
          check("wr_data", mem_data, exp_entry[7:0]);
          $display("write addr=%0d data=%02h", mem_addr, mem_data);
        end
      end
      hold_prev = mem_we && !mem_ready;
      prev_addr = mem_addr;
      prev_data = mem_data;
    end
  end

  // All drive tasks start and end one time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_strobe(input logic [16:0] a, input logic [11:0] d, input bit expect_write);
    wr_en_in   = 1'b1;
    wr_addr_in = a;
    d_in       = d;
    if (expect_write) sb.push_back({a, model_conv(d)});
    @(posedge clk);
    #1;
    wr_en_in = 1'b0;
  endtask

  task automatic do_start();
    start     = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.delete();
  endtask

  task automatic run_frame(input bit with_start);
    int w0;
    bit hit;
    if (with_start) do_start();
    mem_ready = 1'b1;
    w0  = wcount;
    hit = 1'b0;
    fork
      begin
        for (int i = 0; i < 2500; i++) drive_strobe(17'(i), 12'($urandom), 1'b1);
      end
      begin
        for (int c = 0; c < 3000; c++) begin
          @(posedge clk);
          #2;
          if (wcount - w0 == 2499) check("done_early", done, 0);
          if (wcount - w0 >= 2500) begin
            hit = 1'b1;
            break;
          end
        end
      end
    join
    check("frame_timeout", hit, 1);
    check("frame_writes", wcount - w0, 2500);
    check("frame_done", done, 1);
    check("frame_busy", busy, 0);
    check("frame_we", mem_we, 0);
    tick(1);
  endtask

  int          w0;
  logic [7:0]  first_data;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    wr_en_in   = 1'b0;
    wr_addr_in = '0;
    d_in       = '0;
    mem_ready  = 1'b0;
    #1;
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // IDLE ignores strobes
    mem_ready = 1'b1;
    drive_strobe(17'd1, 12'h0A5, 1'b0);
    tick(4);
    check("idle_no_write", mem_we, 0);
    check("idle_busy", busy, 0);

    // Conversion and latency
    do_start();
    check("start_busy", busy, 1);
    check("start_done", done, 0);
    mem_ready = 1'b1;
    drive_strobe(17'd5, 12'h0A5, 1'b1);
    @(negedge clk);
    check("lat_edge_e", mem_we, 0);
    @(negedge clk);
    check("lat_edge_e1", mem_we, 1);
    check("conv_addr", mem_addr, 17'd5);
    check("conv_data", mem_data, 8'h29);
    @(posedge clk);
    #1;
    drive_strobe(17'd6, 12'h7FF, 1'b1);
    drive_strobe(17'd7, 12'h800, 1'b1);
    tick(4);
    check("conv_drain", sb.size(), 0);

    // Backpressure and overflow
    do_start();
    for (int i = 0; i < 4; i++) drive_strobe(17'(100 + i), 12'(16 * i + 40), 1'b1);
    first_data = sb[0][7:0];
    tick(3);
    check("bp_we", mem_we, 1);
    check("bp_head", mem_data, first_data);
    check("bp_no_ovf", overflow, 0);
    drive_strobe(17'd104, 12'h3C0, 1'b0);
    tick(3);
    check("bp_ovf", overflow, 1);
    mem_ready = 1'b1;
    w0 = wcount;
    tick(8);
    check("bp_writes", wcount - w0, 4);
    check("bp_drain", sb.size(), 0);
    check("bp_ovf_sticky", overflow, 1);

    // Full FIFO with a pop on every edge
    do_start();
    check("full_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) drive_strobe(17'(200 + i), 12'($urandom), 1'b1);
    tick(3);
    mem_ready = 1'b1;
    w0 = wcount;
    for (int i = 0; i < 20; i++) drive_strobe(17'(300 + i), 12'($urandom), 1'b1);
    check("full_rate", wcount - w0, 20);
    check("full_no_ovf", overflow, 0);
    tick(8);
    check("full_drain", sb.size(), 0);

    // Whole frame, then a stray strobe in DONE
    run_frame(1'b1);
    w0 = wcount;
    drive_strobe(17'd7, 12'h100, 1'b0);
    tick(4);
    check("done_ignore", wcount - w0, 0);
    check("done_ignore_we", mem_we, 0);
    check("done_hold", done, 1);

    // Restart mid-frame
    do_start();
    mem_ready = 1'b1;
    w0 = wcount;
    for (int i = 0; i < 100; i++) drive_strobe(17'(i), 12'($urandom), 1'b1);
    tick(5);
    check("rs_first100", wcount - w0, 100);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_strobe(17'(500 + i), 12'h200, 1'b0);
    tick(3);
    check("rs_pending", mem_we, 1);
    start      = 1'b1;
    wr_en_in   = 1'b1;
    wr_addr_in = 17'd9;
    d_in       = 12'h100;
    @(posedge clk);
    #1;
    start    = 1'b0;
    wr_en_in = 1'b0;
    sb.delete();
    tick(3);
    check("rs_flush", mem_we, 0);
    check("rs_busy", busy, 1);
    check("rs_done", done, 0);
    run_frame(1'b0);

    // Asynchronous reset while a write is stalled
    do_start();
    for (int i = 0; i < 5; i++) drive_strobe(17'(600 + i), 12'h155, 1'b0);
    tick(4);
    check("ar_pre_we", mem_we, 1);
    check("ar_pre_ovf", overflow, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("ar_we", mem_we, 0);
    check("ar_done", done, 0);
    check("ar_ovf", overflow, 0);
    check("ar_busy", busy, 0);
    check("ar_addr", mem_addr, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
